ether_frame_gen: RTL and testbench



---
 rtl/ether_frame_gen_if.sv | 24 ++
 rtl/ether_frame_gen.sv | 217 +++++++++++++++++++++
 tb/tb_ether_frame_gen.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ether_frame_gen_if.sv
// Control/status and GMII TX bundle for the Ethernet frame generator.
// The master side requests bursts; the slave side (the generator) drives
// burst status and the GMII transmit byte lane.
interface ether_frame_gen_if;
  logic        start;
  logic        stop;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic [15:0] frames_sent;
  logic        er;
  logic        en;
  logic [7:0]  data;

  modport master (
    output start, stop, count,
    input  busy, done, frames_sent, er, en, data
  );

  modport slave (
    input  start, stop, count,
    output busy, done, frames_sent, er, en, data
  );
endinterface

// File: rtl/ether_frame_gen.sv
// GMII TX burst frame generator.
// Emits bursts of Ethernet II frames: preamble, SFD, fixed header, a
// sequence-seeded payload and a CRC-32 FCS, each followed by an idle gap.
// Every output is registered: the next-state logic works out which byte
// goes on the line next and it is captured together with the state.
module ether_frame_gen #(
  parameter logic [47:0] DST_MAC        = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC        = 48'h0011_2233_4455,
  parameter logic [15:0] ETHERTYPE      = 16'h88B5,
  parameter int          PAYLOAD_LEN    = 46,
  parameter int          PREAMBLE_BYTES = 7,
  parameter int          IFG_BYTES      = 12
) (
  input  logic             clk,
  input  logic             rst,
  ether_frame_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_HDR,
    S_PAY,
    S_FCS,
    S_IFG
  } state_t;

  localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [10:0]  PRE_LAST  = 11'(PREAMBLE_BYTES - 1);
  localparam logic [10:0]  PAY_LAST  = 11'(PAYLOAD_LEN - 1);
  localparam logic [10:0]  HDR_LAST  = 11'd13;
  localparam logic [10:0]  FCS_LAST  = 11'd3;
  localparam logic [7:0]   IFG_LAST  = 8'(IFG_BYTES - 1);
  localparam logic [31:0]  CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0]  CRC_POLY  = 32'hEDB8_8320;

  // Reflected CRC-32 advanced by one byte, bit 0 of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Header byte i, destination MAC most significant byte first.
  function automatic logic [7:0] hdr_byte(input logic [10:0] i);
    logic [111:0] sh;
    sh = HDR_BYTES << {i, 3'b000};
    return sh[111:104];
  endfunction

  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic [7:0]  ifg_q, ifg_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] count_q, count_d;
  logic [15:0] frames_q, frames_d;
  logic [31:0] crc_q, crc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        en_q, en_d;
  logic [7:0]  data_q, data_d;

  logic [31:0] crc_nx;
  logic [31:0] fcs;

  // Next state, counters, CRC and the byte to place on the line next cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ifg_d    = ifg_q;
    seq_d    = seq_q;
    count_d  = count_q;
    frames_d = frames_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // The byte currently on the line (data_q) is folded in while it is a
    // header or payload byte, so the FCS is ready the cycle after the last
    // payload byte. Re-seeding in SFD keeps frames independent.
    crc_nx = ((state_q == S_HDR) || (state_q == S_PAY)) ? crc32_byte(crc_q, data_q) : crc_q;
    crc_d  = (state_q == S_SFD) ? CRC_INIT : crc_nx;
    fcs    = ~crc_nx;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_PRE;
          idx_d    = '0;
          count_d  = bus.count;
          frames_d = '0;
          seq_d    = '0;
          busy_d   = 1'b1;
        end
      end
      S_PRE: begin
        if (idx_q == PRE_LAST) begin
          state_d = S_SFD;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      S_SFD: begin
        state_d = S_HDR;
        idx_d   = '0;
      end
      S_HDR: begin
        if (idx_q == HDR_LAST) begin
          state_d = S_PAY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      S_PAY: begin
        if (idx_q == PAY_LAST) begin
          state_d = S_FCS;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      S_FCS: begin
        if (idx_q == FCS_LAST) begin
          state_d = S_IFG;
          ifg_d   = '0;
        end else begin
          idx_d = idx_q + 11'd1;
          // The frame counts as sent as its final FCS byte goes out.
          if (idx_q == FCS_LAST - 11'd1) begin
            frames_d = frames_q + 16'd1;
            seq_d    = seq_q + 8'd1;
          end
        end
      end
      S_IFG: begin
        if (ifg_q == IFG_LAST) begin
          if (bus.stop || ((count_q != 16'd0) && (frames_q == count_q))) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_PRE;
            idx_d   = '0;
          end
        end else begin
          ifg_d = ifg_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    en_d = (state_d == S_PRE) || (state_d == S_SFD) || (state_d == S_HDR) ||
           (state_d == S_PAY) || (state_d == S_FCS);

    unique case (state_d)
      S_PRE:   data_d = 8'h55;
      S_SFD:   data_d = 8'hD5;
      S_HDR:   data_d = hdr_byte(idx_d);
      S_PAY:   data_d = seq_q + idx_d[7:0];
      S_FCS: begin
        unique case (idx_d[1:0])
          2'd0:    data_d = fcs[7:0];
          2'd1:    data_d = fcs[15:8];
          2'd2:    data_d = fcs[23:16];
          default: data_d = fcs[31:24];
        endcase
      end
      default: data_d = 8'h00;
    endcase
  end

  // State, counters and registered outputs; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ifg_q    <= '0;
      seq_q    <= '0;
      count_q  <= '0;
      frames_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ifg_q    <= ifg_d;
      seq_q    <= seq_d;
      count_q  <= count_d;
      frames_q <= frames_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      data_q   <= data_d;
    end
    // CRC is pure datapath and is re-seeded in SFD before it is ever used.
    crc_q <= crc_d;
  end

  assign bus.en          = en_q;
  assign bus.data        = data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frames_sent = frames_q;
  // The generator never signals a transmit error.
  assign bus.er          = 1'b0;

endmodule

// File: tb/tb_ether_frame_gen.sv
// Bench for ether_frame_gen: default-parameter instance driven from a
// vector table plus reset corner case, and a large-frame instance.
`timescale 1ns/1ps
module tb_ether_frame_gen;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  ether_frame_gen_if b0 ();
  ether_frame_gen_if b1 ();

  ether_frame_gen dut0 (.clk(clk), .rst(rst), .bus(b0));

  ether_frame_gen #(
    .PAYLOAD_LEN(1500), .PREAMBLE_BYTES(1), .IFG_BYTES(255)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int p_pre(input int d); return (d == 0) ? 7 : 1; endfunction
  function automatic int p_pay(input int d); return (d == 0) ? 46 : 1500; endfunction
  function automatic int p_ifg(input int d); return (d == 0) ? 12 : 255; endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] crc_b(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // Expected on-the-wire byte i (FCS excluded) of frame seq s.
  function automatic logic [7:0] exp_byte(input int d, input int s, input int i);
    int j;
    if (i < p_pre(d)) return 8'h55;
    if (i == p_pre(d)) return 8'hD5;
    j = i - p_pre(d) - 1;
    if (j < 6) return 8'hFF;
    if (j < 12) return 8'((j - 6) * 17);
    if (j == 12) return 8'h88;
    if (j == 13) return 8'hB5;
    return 8'((s + j - 14) & 255);
  endfunction

  // Monitor state per instance.
  bit         in_fr[2];
  int         flen[2];
  logic [7:0] fbuf[2][2048];
  int         gap[2];
  bit         gap_ok[2];
  int         frames_obs[2];
  int         done_cnt[2];
  bit         er_seen[2];
  int         sbq0[$];
  int         sbq1[$];

  task automatic check_frame(input int d, input logic [15:0] fs);
    int exp_len, seqn, bad, lim;
    logic [31:0] c;
    exp_len = p_pre(d) + 1 + 14 + p_pay(d) + 4;
    chk("frame_len", flen[d], exp_len);
    frames_obs[d]++;
    if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
      fail_now("unexpected_frame");
      return;
    end
    seqn = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
    lim = (flen[d] < 2048) ? flen[d] : 2048;
    bad = 0;
    for (int i = 0; i < exp_len - 4; i++) begin
      if (i >= lim) bad++;
      else if (fbuf[d][i] !== exp_byte(d, seqn, i)) bad++;
    end
    chk("frame_bad_bytes", bad, 0);
    c = 32'hFFFF_FFFF;
    for (int i = p_pre(d) + 1; i < lim; i++) c = crc_b(c, fbuf[d][i]);
    chk("crc_residue", c, 32'hDEBB_20E3);
    chk("frames_sent_at_frame_end", fs, seqn + 1);
    chk("er_low", er_seen[d], 0);
    er_seen[d] = 1'b0;
  endtask

  task automatic mon(input int d, input logic r, input logic en, input logic er,
                     input logic [7:0] data, input logic done, input logic busy,
                     input logic [15:0] fs);
    if (r) begin
      in_fr[d] = 1'b0; flen[d] = 0; gap[d] = 0; gap_ok[d] = 1'b0;
      return;
    end
    if (er) er_seen[d] = 1'b1;
    if (en) begin
      if (!in_fr[d]) begin
        if (gap_ok[d]) chk("ifg_gap", gap[d], p_ifg(d));
        chk("busy_in_frame", busy, 1);
        in_fr[d] = 1'b1;
        flen[d] = 0;
      end
      if (flen[d] < 2048) fbuf[d][flen[d]] = data;
      flen[d]++;
    end else begin
      if (in_fr[d]) begin
        in_fr[d] = 1'b0;
        check_frame(d, fs);
        gap[d] = 0;
        gap_ok[d] = 1'b1;
      end
      if (done) begin
        done_cnt[d]++;
        chk("gap_before_done", gap[d], p_ifg(d));
        chk("busy_low_at_done", busy, 0);
        gap_ok[d] = 1'b0;
      end
      gap[d]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst, b0.en, b0.er, b0.data, b0.done, b0.busy, b0.frames_sent);
    mon(1, rst, b1.en, b1.er, b1.data, b1.done, b1.busy, b1.frames_sent);
  end

  typedef struct {
    logic [15:0] count;
    int          stop_frame;   // raise stop and hold it in PAY of this frame
    int          pulse_frame;  // one-cycle stop pulse in PAY of this frame
    bit          hold_stop;    // stop high together with start
    bit          poke;         // start pulses and count change mid-burst
    int          exp_frames;
  } vec_t;

  task automatic run_row(input vec_t v, input string tag);
    int base_f, base_d, cyc, fn;
    @(posedge clk); #1;
    b0.count = v.count;
    b0.stop  = v.hold_stop;
    b0.start = 1'b1;
    for (int i = 0; i < v.exp_frames; i++) sbq0.push_back(i);
    base_f = frames_obs[0];
    base_d = done_cnt[0];
    @(posedge clk); #1;
    b0.start = 1'b0;
    chk({tag, "_busy_after_start"}, b0.busy, 1);
    chk({tag, "_en_after_start"}, b0.en, 1);
    cyc = 0;
    while (done_cnt[0] == base_d && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      fn = frames_obs[0] - base_f + 1;
      if (in_fr[0] && flen[0] == 30) begin
        if (v.stop_frame == fn || v.pulse_frame == fn) b0.stop = 1'b1;
      end
      if (in_fr[0] && flen[0] == 31 && v.pulse_frame == fn) b0.stop = 1'b0;
      if (v.poke) begin
        if (in_fr[0] && fn == 2 && flen[0] == 10) begin b0.start = 1'b1; b0.count = 16'd1; end
        if (in_fr[0] && fn == 2 && flen[0] == 11) b0.start = 1'b0;
        if (!in_fr[0] && fn == 2 && gap[0] == 5) b0.start = 1'b1;
        if (!in_fr[0] && fn == 2 && gap[0] == 6) b0.start = 1'b0;
      end
    end
    if (cyc >= 4000) fail_now({tag, "_done_timeout"});
    b0.stop  = 1'b0;
    b0.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_frames_in_burst"}, frames_obs[0] - base_f, v.exp_frames);
    chk({tag, "_done_pulses"}, done_cnt[0] - base_d, 1);
    chk({tag, "_frames_sent_final"}, b0.frames_sent, v.exp_frames);
    chk({tag, "_busy_idle"}, b0.busy, 0);
    chk({tag, "_en_idle"}, b0.en, 0);
    chk({tag, "_scoreboard_drained"}, sbq0.size(), 0);
    sbq0.delete();
  endtask

  vec_t vecs[5];

  initial begin
    int cyc, base_f, base_d;
    vecs[0] = '{16'd1, 0, 0, 1'b0, 1'b0, 1};
    vecs[1] = '{16'd3, 0, 0, 1'b0, 1'b1, 3};
    vecs[2] = '{16'd0, 5, 0, 1'b0, 1'b0, 5};
    vecs[3] = '{16'd0, 4, 2, 1'b0, 1'b0, 4};
    vecs[4] = '{16'd2, 0, 0, 1'b1, 1'b0, 1};

    rst = 1'b1;
    b0.start = 1'b0; b0.stop = 1'b0; b0.count = 16'd0;
    b1.start = 1'b0; b1.stop = 1'b0; b1.count = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", b0.en, 0);
    chk("reset_er", b0.er, 0);
    chk("reset_data", b0.data, 0);
    chk("reset_busy", b0.busy, 0);
    chk("reset_done", b0.done, 0);
    chk("reset_frames_sent", b0.frames_sent, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 5; r++) run_row(vecs[r], $sformatf("row%0d", r));

    // Reset in the payload of the second frame of a continuous burst.
    @(posedge clk); #1;
    b0.count = 16'd0;
    b0.start = 1'b1;
    sbq0.push_back(0);
    base_f = frames_obs[0];
    @(posedge clk); #1;
    b0.start = 1'b0;
    cyc = 0;
    while (!(frames_obs[0] - base_f == 1 && in_fr[0] && flen[0] == 40) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 1000) fail_now("reset_wait_timeout");
    chk("pre_reset_frames_sent", b0.frames_sent, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midframe_reset_en", b0.en, 0);
    chk("midframe_reset_busy", b0.busy, 0);
    chk("midframe_reset_frames_sent", b0.frames_sent, 0);
    chk("midframe_reset_data", b0.data, 0);
    rst = 1'b0;
    sbq0.delete();
    repeat (2) @(posedge clk);
    run_row('{16'd1, 0, 0, 1'b0, 1'b0, 1}, "after_reset");

    // Large payload, single-byte preamble, maximum gap.
    @(posedge clk); #1;
    b1.count = 16'd2;
    b1.start = 1'b1;
    sbq1.push_back(0);
    sbq1.push_back(1);
    base_f = frames_obs[1];
    base_d = done_cnt[1];
    @(posedge clk); #1;
    b1.start = 1'b0;
    cyc = 0;
    while (done_cnt[1] == base_d && cyc < 8000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 8000) fail_now("sweep_done_timeout");
    chk("sweep_frames", frames_obs[1] - base_f, 2);
    chk("sweep_frames_sent", b1.frames_sent, 2);
    chk("sweep_scoreboard_drained", sbq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
